abh: RTL and testbench

Address Bus High stage for the microcoded 65C02 core. Sits directly downstream of the address-low stage: consumes its carry out (`CI`) and PCL carry (`pcl_co`), and produces the upper 8 bits of the 16-bit address bus. Also maintains the AHH hold register, the PCH program counter and a registered page-cross flag that the microcode sequencer uses as a condition input.

---
 rtl/abh_pkg.sv | 39 +++
 rtl/abh_if.sv | 30 +++
 rtl/abh_add.sv | 50 +++++
 rtl/inc8.sv | 13 +
 rtl/reg8.sv | 20 ++
 rtl/abh.sv | 82 ++++++++
 tb/tb_abh.sv | 182 ++++++++++++++++++
 7 files changed

// File: rtl/abh_pkg.sv
// abh_pkg: shared constants for the address-bus-high stage.
//   - ABH_* : high-address operation codes carried in the microcode word,
//             kept next to the address-low op codes of the core.
//   - *_PAGE: fixed page numbers selected by the constant ops.
//   - page_cross(): next value of the PX condition flag.
package abh_pkg;

    localparam logic [2:0] ABH_PC   = 3'b000;  // restore from PCH
    localparam logic [2:0] ABH_STK  = 3'b001;  // stack page
    localparam logic [2:0] ABH_VEC  = 3'b010;  // vector page
    localparam logic [2:0] ABH_KEEP = 3'b011;  // stay / next page
    localparam logic [2:0] ABH_ZP   = 3'b100;  // zero page
    localparam logic [2:0] ABH_DB   = 3'b101;  // high operand on data bus
    localparam logic [2:0] ABH_AHH  = 3'b110;  // held high operand
    localparam logic [2:0] ABH_REL  = 3'b111;  // relative branch

    localparam logic [7:0] ZERO_PAGE   = 8'h00;
    localparam logic [7:0] STACK_PAGE  = 8'h01;
    localparam logic [7:0] VECTOR_PAGE = 8'hFF;

    // Indexed modes cross a page exactly when the low adder carries; a
    // branch crosses when the new high byte differs from the current one,
    // which covers both forward and backward cases. Every other op is a
    // plain page selection and never reports a cross.
    function automatic logic page_cross(input logic [2:0] op,
                                        input logic       ci,
                                        input logic [7:0] adh,
                                        input logic [7:0] abh);
        logic px;
        px = 1'b0;
        case (op)
            ABH_DB, ABH_AHH: px = ci;
            ABH_REL:         px = (adh != abh);
            default:         px = 1'b0;
        endcase
        return px;
    endfunction

endpackage

// File: rtl/abh_if.sv
// abh_if: microcode/bus-side signals of the address-bus-high stage.
//   Inputs to the stage : rdy, CI, DB[7:0], op[2:0], ld_ahh, ld_pc, pcl_co
//   Outputs of the stage: ADH[7:0] (combinational), ABH[7:0], PCH[7:0], PX
//   master: the sequencer / address-low side driving the stage
//   slave : the abh stage itself
interface abh_if;

    logic       rdy;
    logic       CI;
    logic [7:0] DB;
    logic [2:0] op;
    logic       ld_ahh;
    logic       ld_pc;
    logic       pcl_co;
    logic [7:0] ADH;
    logic [7:0] ABH;
    logic [7:0] PCH;
    logic       PX;

    modport master (
        output rdy, CI, DB, op, ld_ahh, ld_pc, pcl_co,
        input  ADH, ABH, PCH, PX
    );

    modport slave (
        input  rdy, CI, DB, op, ld_ahh, ld_pc, pcl_co,
        output ADH, ABH, PCH, PX
    );

endinterface

// File: rtl/abh_add.sv
// abh_add: next high address generator.
//   op[2:0]  : high-address operation (ABH_* codes)
//   CI       : carry from the address-low adder (late arriving)
//   DB[7:0]  : data bus
//   AHH, ABH, PCH : current hold register, address high, PC high
//   ADH[7:0] : next high address, modulo 256
module abh_add
    import abh_pkg::*;
(
    input  logic [2:0] op,
    input  logic       CI,
    input  logic [7:0] DB,
    input  logic [7:0] AHH,
    input  logic [7:0] ABH,
    input  logic [7:0] PCH,
    output logic [7:0] ADH
);

    logic [7:0] base;
    logic [7:0] ext;
    logic       ci_use;
    logic [7:0] pre_sum;

    always_comb begin
        base   = PCH;
        ext    = 8'h00;
        ci_use = 1'b0;
        case (op)
            ABH_PC:   base = PCH;
            ABH_STK:  base = STACK_PAGE;
            ABH_VEC:  base = VECTOR_PAGE;
            ABH_KEEP: begin base = ABH; ci_use = 1'b1; end
            ABH_ZP:   base = ZERO_PAGE;
            ABH_DB:   begin base = DB;  ci_use = 1'b1; end
            ABH_AHH:  begin base = AHH; ci_use = 1'b1; end
            ABH_REL:  begin
                base   = ABH;
                ext    = {8{DB[7]}};
                ci_use = 1'b1;
            end
            default:  base = PCH;
        endcase
    end

    // Base and sign extension are summed first so the late CI only passes
    // through the final incrementing add.
    assign pre_sum = base + ext;
    assign ADH     = pre_sum + {7'b0, CI & ci_use};

endmodule

// File: rtl/inc8.sv
// inc8: 8-bit conditional incrementer, Y = A + CI modulo 256.
//   A  : operand
//   CI : increment request
//   Y  : result (carry out discarded)
module inc8 (
    input  logic [7:0] A,
    input  logic       CI,
    output logic [7:0] Y
);

    assign Y = A + {7'b0, CI};

endmodule

// File: rtl/reg8.sv
// reg8: 8-bit register primitive with synchronous active-high reset and
// load enable. Reset has priority over the enable.
//   clk, RST, EN : clock, reset, load enable
//   D / Q        : data in / registered data out
module reg8 (
    input  logic       clk,
    input  logic       RST,
    input  logic       EN,
    input  logic [7:0] D,
    output logic [7:0] Q
);

    always_ff @(posedge clk) begin
        if (RST)
            Q <= 8'h00;
        else if (EN)
            Q <= D;
    end

endmodule

// File: rtl/abh.sv
// abh: address-bus-high stage of the microcoded 65C02 core.
//   clk  : core clock, rising edge
//   RST  : synchronous active-high reset, clears every register
//   bus  : abh_if.slave
//          in : rdy, CI, DB, op, ld_ahh, ld_pc, pcl_co
//          out: ADH (combinational next high address), ABH (registered),
//               PCH (program counter high), PX (registered page cross)
module abh
    import abh_pkg::*;
(
    input  logic  clk,
    input  logic  RST,
    abh_if.slave  bus
);

    logic [7:0] adh;
    logic [7:0] abh_q;
    logic [7:0] ahh_q;
    logic [7:0] pch_q;
    logic [7:0] pch_d;
    logic       px_d;
    logic       px_q;

    abh_add u_add (
        .op  (bus.op),
        .CI  (bus.CI),
        .DB  (bus.DB),
        .AHH (ahh_q),
        .ABH (abh_q),
        .PCH (pch_q),
        .ADH (adh)
    );

    reg8 u_abh_reg (
        .clk (clk),
        .RST (RST),
        .EN  (bus.rdy),
        .D   (adh),
        .Q   (abh_q)
    );

    // AHH is loaded regardless of rdy; the microcode only asserts ld_ahh
    // in cycles where the data bus is valid.
    reg8 u_ahh_reg (
        .clk (clk),
        .RST (RST),
        .EN  (bus.ld_ahh),
        .D   (bus.DB),
        .Q   (ahh_q)
    );

    // PCH follows the pre-edge ABH so it stays aligned with PCL, which the
    // address-low stage updates on the same edge.
    inc8 u_pch_inc (
        .A  (abh_q),
        .CI (bus.pcl_co),
        .Y  (pch_d)
    );

    reg8 u_pch_reg (
        .clk (clk),
        .RST (RST),
        .EN  (bus.ld_pc),
        .D   (pch_d),
        .Q   (pch_q)
    );

    assign px_d = page_cross(bus.op, bus.CI, adh, abh_q);

    always_ff @(posedge clk) begin
        if (RST)
            px_q <= 1'b0;
        else if (bus.rdy)
            px_q <= px_d;
    end

    assign bus.ADH = adh;
    assign bus.ABH = abh_q;
    assign bus.PCH = pch_q;
    assign bus.PX  = px_q;

endmodule

// File: tb/tb_abh.sv
// tb_abh: directed testbench for the abh stage.
module tb_abh;

    logic clk;
    logic RST;
    int   total;
    int   bad;

    abh_if u_if ();

    abh dut (
        .clk (clk),
        .RST (RST),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; u_if.ld_ahh = 1'b1; u_if.ld_pc = 1'b1; u_if.rdy = 1'b1;
        u_if.DB = 8'h5A; u_if.op = 3'b011; u_if.CI = 1'b1; u_if.pcl_co = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h00) begin bad++; $display("FAIL rst_abh got=%h exp=00", u_if.ABH); end
        total++; if (u_if.PCH !== 8'h00) begin bad++; $display("FAIL rst_pch got=%h exp=00", u_if.PCH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL rst_px got=%b exp=0", u_if.PX); end
        RST = 1'b0; u_if.ld_ahh = 1'b0; u_if.ld_pc = 1'b0; u_if.rdy = 1'b0;
        u_if.op = 3'b110; u_if.CI = 1'b0; u_if.pcl_co = 1'b0;
        #1;
        total++; if (u_if.ADH !== 8'h00) begin bad++; $display("FAIL rst_ahh got=%h exp=00", u_if.ADH); end
    endtask

    task automatic test_indexed();
        u_if.DB = 8'h12; u_if.ld_ahh = 1'b1; u_if.rdy = 1'b0; u_if.op = 3'b000;
        tick();
        u_if.ld_ahh = 1'b0; u_if.DB = 8'h00; u_if.op = 3'b110; u_if.CI = 1'b1; u_if.rdy = 1'b1;
        #1;
        total++; if (u_if.ADH !== 8'h13) begin bad++; $display("FAIL idx_adh got=%h exp=13", u_if.ADH); end
        tick();
        total++; if (u_if.ABH !== 8'h13) begin bad++; $display("FAIL idx_abh got=%h exp=13", u_if.ABH); end
        total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL idx_px got=%b exp=1", u_if.PX); end
        u_if.CI = 1'b0;
        tick();
        total++; if (u_if.ABH !== 8'h12) begin bad++; $display("FAIL idx_nc_abh got=%h exp=12", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL idx_nc_px got=%b exp=0", u_if.PX); end
        u_if.op = 3'b101; u_if.DB = 8'h7F; u_if.CI = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h80) begin bad++; $display("FAIL abs_abh got=%h exp=80", u_if.ABH); end
        total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL abs_px got=%b exp=1", u_if.PX); end
        // load and use of AHH in the same cycle sees the old value
        u_if.op = 3'b110; u_if.ld_ahh = 1'b1; u_if.DB = 8'h40; u_if.CI = 1'b0;
        #1;
        total++; if (u_if.ADH !== 8'h12) begin bad++; $display("FAIL ahh_old_adh got=%h exp=12", u_if.ADH); end
        tick();
        total++; if (u_if.ABH !== 8'h12) begin bad++; $display("FAIL ahh_old_abh got=%h exp=12", u_if.ABH); end
        u_if.ld_ahh = 1'b0; u_if.DB = 8'h00;
        #1;
        total++; if (u_if.ADH !== 8'h40) begin bad++; $display("FAIL ahh_new_adh got=%h exp=40", u_if.ADH); end
    endtask

    task automatic test_branch();
        u_if.rdy = 1'b1; u_if.op = 3'b101; u_if.DB = 8'h20; u_if.CI = 1'b0;
        tick();
        u_if.op = 3'b111; u_if.DB = 8'hF0;
        #1;
        total++; if (u_if.ADH !== 8'h1F) begin bad++; $display("FAIL br_back_adh got=%h exp=1F", u_if.ADH); end
        tick();
        total++; if (u_if.ABH !== 8'h1F) begin bad++; $display("FAIL br_back_abh got=%h exp=1F", u_if.ABH); end
        total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL br_back_px got=%b exp=1", u_if.PX); end
        u_if.op = 3'b101; u_if.DB = 8'h20;
        tick();
        u_if.op = 3'b111; u_if.DB = 8'h05;
        tick();
        total++; if (u_if.ABH !== 8'h20) begin bad++; $display("FAIL br_same_abh got=%h exp=20", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL br_same_px got=%b exp=0", u_if.PX); end
        u_if.CI = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h21) begin bad++; $display("FAIL br_fwd_abh got=%h exp=21", u_if.ABH); end
        total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL br_fwd_px got=%b exp=1", u_if.PX); end
        u_if.DB = 8'hF0;
        tick();
        total++; if (u_if.ABH !== 8'h21) begin bad++; $display("FAIL br_negc_abh got=%h exp=21", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL br_negc_px got=%b exp=0", u_if.PX); end
    endtask

    task automatic test_wrap();
        u_if.rdy = 1'b1; u_if.op = 3'b101; u_if.DB = 8'hFF; u_if.CI = 1'b0;
        tick();
        u_if.op = 3'b011; u_if.CI = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h00) begin bad++; $display("FAIL wrap_abh got=%h exp=00", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL wrap_px got=%b exp=0", u_if.PX); end
        u_if.rdy = 1'b0; u_if.ld_pc = 1'b1; u_if.pcl_co = 1'b1;
        tick();
        total++; if (u_if.PCH !== 8'h01) begin bad++; $display("FAIL wrap_pch got=%h exp=01", u_if.PCH); end
        u_if.ld_pc = 1'b0; u_if.pcl_co = 1'b0;
        u_if.rdy = 1'b1; u_if.op = 3'b101; u_if.DB = 8'hC2; u_if.CI = 1'b0;
        tick();
        // ABH update and PCH load on the same edge: PCH takes the old ABH
        u_if.op = 3'b011; u_if.CI = 1'b1; u_if.ld_pc = 1'b1; u_if.pcl_co = 1'b0;
        tick();
        total++; if (u_if.ABH !== 8'hC3) begin bad++; $display("FAIL simul_abh got=%h exp=C3", u_if.ABH); end
        total++; if (u_if.PCH !== 8'hC2) begin bad++; $display("FAIL simul_pch got=%h exp=C2", u_if.PCH); end
        u_if.rdy = 1'b0;
        tick();
        total++; if (u_if.PCH !== 8'hC3) begin bad++; $display("FAIL pch_load got=%h exp=C3", u_if.PCH); end
        u_if.ld_pc = 1'b0;
    endtask

    task automatic test_rdy_hold();
        u_if.rdy = 1'b1; u_if.op = 3'b110; u_if.CI = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h41) begin bad++; $display("FAIL hold_pre_abh got=%h exp=41", u_if.ABH); end
        u_if.rdy = 1'b0; u_if.op = 3'b001; u_if.CI = 1'b1;
        #1;
        total++; if (u_if.ADH !== 8'h01) begin bad++; $display("FAIL hold_adh got=%h exp=01", u_if.ADH); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (u_if.ABH !== 8'h41) begin bad++; $display("FAIL hold_abh[%0d] got=%h exp=41", i, u_if.ABH); end
            total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL hold_px[%0d] got=%b exp=1", i, u_if.PX); end
        end
        u_if.rdy = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'h01) begin bad++; $display("FAIL hold_rel_abh got=%h exp=01", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL hold_rel_px got=%b exp=0", u_if.PX); end
    endtask

    task automatic test_fixed_pages();
        u_if.rdy = 1'b1; u_if.op = 3'b010; u_if.CI = 1'b1;
        tick();
        total++; if (u_if.ABH !== 8'hFF) begin bad++; $display("FAIL vec_abh got=%h exp=FF", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL vec_px got=%b exp=0", u_if.PX); end
        u_if.op = 3'b100;
        #1;
        total++; if (u_if.ADH !== 8'h00) begin bad++; $display("FAIL zp_adh got=%h exp=00", u_if.ADH); end
        tick();
        total++; if (u_if.ABH !== 8'h00) begin bad++; $display("FAIL zp_abh got=%h exp=00", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL zp_px got=%b exp=0", u_if.PX); end
        u_if.op = 3'b000;
        tick();
        total++; if (u_if.ABH !== 8'hC3) begin bad++; $display("FAIL pc_abh got=%h exp=C3", u_if.ABH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL pc_px got=%b exp=0", u_if.PX); end
    endtask

    task automatic test_mid_reset();
        u_if.rdy = 1'b1; u_if.op = 3'b110; u_if.CI = 1'b1;
        tick();
        total++; if (u_if.PX !== 1'b1) begin bad++; $display("FAIL mid_pre_px got=%b exp=1", u_if.PX); end
        RST = 1'b1; u_if.rdy = 1'b0; u_if.ld_ahh = 1'b1; u_if.ld_pc = 1'b1; u_if.DB = 8'h77;
        tick();
        total++; if (u_if.ABH !== 8'h00) begin bad++; $display("FAIL mid_abh got=%h exp=00", u_if.ABH); end
        total++; if (u_if.PCH !== 8'h00) begin bad++; $display("FAIL mid_pch got=%h exp=00", u_if.PCH); end
        total++; if (u_if.PX !== 1'b0) begin bad++; $display("FAIL mid_px got=%b exp=0", u_if.PX); end
        RST = 1'b0; u_if.ld_ahh = 1'b0; u_if.ld_pc = 1'b0; u_if.CI = 1'b0; u_if.DB = 8'h00;
        #1;
        total++; if (u_if.ADH !== 8'h00) begin bad++; $display("FAIL mid_ahh got=%h exp=00", u_if.ADH); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST = 1'b0;
        u_if.rdy = 1'b0; u_if.CI = 1'b0; u_if.DB = 8'h00; u_if.op = 3'b000;
        u_if.ld_ahh = 1'b0; u_if.ld_pc = 1'b0; u_if.pcl_co = 1'b0;
        #1;
        test_reset();
        test_indexed();
        test_branch();
        test_wrap();
        test_rdy_hold();
        test_fixed_pages();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
